// File: rtl/htu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : htu_pkg
//  Purpose  : Shared types and constants for the htu_down BCD countdown timer.
//  Contents : bcd_t digit type, htu_state_e FSM states, BCD_MAX, clamp_bcd().
//  Revision : 1.0  initial release
// ============================================================================
package htu_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } htu_state_e;

  localparam bcd_t BCD_MAX = 4'd9;

  // Saturate a preset digit at the configured maximum digit value.
  function automatic bcd_t clamp_bcd(input bcd_t val, input bcd_t lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/htu_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : htu_if
//  Purpose  : Control and digit bus of the htu_down countdown timer.
//  Ports    : none (signal bundle only)
//    master : drives load/load_hun/load_ten/load_uni/start/hold/abort,
//             observes hun/ten/uni/busy/done/zero
//    slave  : the timer side, opposite directions
//  Revision : 1.0  initial release
// ============================================================================
interface htu_if;
  import htu_pkg::*;

  logic load;
  bcd_t load_hun;
  bcd_t load_ten;
  bcd_t load_uni;
  logic start;
  logic hold;
  logic abort;
  bcd_t hun;
  bcd_t ten;
  bcd_t uni;
  logic busy;
  logic done;
  logic zero;

  modport master (
    output load, load_hun, load_ten, load_uni, start, hold, abort,
    input  hun, ten, uni, busy, done, zero
  );

  modport slave (
    input  load, load_hun, load_ten, load_uni, start, hold, abort,
    output hun, ten, uni, busy, done, zero
  );

endinterface
`default_nettype wire

// File: rtl/htu_down_digit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_down
//  Purpose  : One down-counting BCD digit with clamped parallel load.
//  Ports    : clk, rst (async, active-low)
//             i_dec_en     decrement this digit
//             i_load       capture i_load_val (wins over i_dec_en)
//             i_load_val   preset value, saturated at i_clamp
//             i_clamp      maximum digit value, also the borrow wrap value
//             o_digit      current digit
//             o_borrow_out decrement requested while digit is 0
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_down
  import htu_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  i_dec_en,
  input  wire  i_load,
  input  bcd_t i_load_val,
  input  bcd_t i_clamp,
  output bcd_t o_digit,
  output logic o_borrow_out
);

  bcd_t r_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= clamp_bcd(i_load_val, i_clamp);
    end else if (i_dec_en) begin
      r_digit <= (r_digit == 4'd0) ? i_clamp : (r_digit - 4'd1);
    end
  end

  assign o_digit      = r_digit;
  assign o_borrow_out = i_dec_en && (r_digit == 4'd0);

endmodule
`default_nettype wire

// File: rtl/htu_down.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : htu_down
//  Purpose  : Three-digit BCD countdown timer. Loaded with a BCD preset, it
//             counts to 000 at a prescaled rate and then pulses done.
//  Params   : UL  maximum digit value (load clamp and borrow wrap)
//             DIV clock cycles per decrement (>= 1)
//  Ports    : clk  rising-edge clock
//             rst  asynchronous, active-low reset
//             bus  htu_if.slave: load/presets/start/hold/abort in,
//                  hun/ten/uni/busy/done/zero out
//  Revision : 1.0  initial release
// ============================================================================
module htu_down
  import htu_pkg::*;
#(
  parameter int UL  = int'(BCD_MAX),
  parameter int DIV = 1
) (
  input  wire   clk,
  input  wire   rst,
  htu_if.slave  bus
);

  localparam int   c_PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam bcd_t c_UL     = bcd_t'(UL);
  localparam logic [c_PW-1:0] c_DIV_M1 = c_PW'(DIV - 1);

  htu_state_e      r_state, w_state_nxt;
  logic [c_PW-1:0] r_presc, w_presc_nxt;

  bcd_t w_hun, w_ten, w_uni;
  logic w_uni_borrow, w_ten_borrow, w_hun_borrow;
  logic w_load_ok, w_load_zero, w_zero, w_zero_after_load;
  logic w_tick, w_dec, w_last;

  // abort outranks load; load is only accepted while idle or held.
  assign w_load_ok = bus.load && !bus.abort && (r_state == IDLE || r_state == HOLD);

  // Clamping never turns a nonzero digit into zero, so the raw zero test holds.
  assign w_load_zero = (bus.load_hun == 4'd0) && (bus.load_ten == 4'd0) &&
                       (bus.load_uni == 4'd0);
  assign w_zero            = (w_hun == 4'd0) && (w_ten == 4'd0) && (w_uni == 4'd0);
  assign w_zero_after_load = w_load_ok ? w_load_zero : w_zero;

  assign w_tick = (r_state == RUN) && !bus.hold && !bus.abort && (r_presc == c_DIV_M1);
  assign w_dec  = w_tick && !w_zero;

  // The tick that leaves 000 behind is the one applied to 001. A hundreds
  // borrow cannot occur while decrement is gated at 000; it is still treated
  // as terminal so a corrupted count can never keep running.
  assign w_last = (w_dec && (w_hun == 4'd0) && (w_ten == 4'd0) && (w_uni == 4'd1)) ||
                  w_hun_borrow;

  bcd_digit_down u_uni (
    .clk          (clk),
    .rst          (rst),
    .i_dec_en     (w_dec),
    .i_load       (w_load_ok),
    .i_load_val   (bus.load_uni),
    .i_clamp      (c_UL),
    .o_digit      (w_uni),
    .o_borrow_out (w_uni_borrow)
  );

  bcd_digit_down u_ten (
    .clk          (clk),
    .rst          (rst),
    .i_dec_en     (w_uni_borrow),
    .i_load       (w_load_ok),
    .i_load_val   (bus.load_ten),
    .i_clamp      (c_UL),
    .o_digit      (w_ten),
    .o_borrow_out (w_ten_borrow)
  );

  bcd_digit_down u_hun (
    .clk          (clk),
    .rst          (rst),
    .i_dec_en     (w_ten_borrow),
    .i_load       (w_load_ok),
    .i_load_val   (bus.load_hun),
    .i_clamp      (c_UL),
    .o_digit      (w_hun),
    .o_borrow_out (w_hun_borrow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_presc_nxt = '0;
          if (bus.start) w_state_nxt = w_zero_after_load ? DONE : RUN;
        end
        RUN: begin
          if (bus.hold) begin
            w_state_nxt = HOLD;
          end else begin
            w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
            if (w_last) w_state_nxt = DONE;
          end
        end
        HOLD: begin
          // Prescaler is left untouched so the period resumes where it paused.
          if (!bus.hold) w_state_nxt = w_zero_after_load ? DONE : RUN;
        end
        DONE: begin
          w_presc_nxt = '0;
          w_state_nxt = IDLE;
        end
        default: begin
          w_presc_nxt = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.hun  = w_hun;
  assign bus.ten  = w_ten;
  assign bus.uni  = w_uni;
  assign bus.zero = w_zero;
  assign bus.busy = (r_state == RUN) || (r_state == HOLD);
  assign bus.done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_htu_down.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_htu_down
//  Purpose  : Self-checking bench for htu_down. Two instances (DIV=1, DIV=4)
//             share one stimulus stream; each has an integer-valued reference
//             model feeding an expectation queue drained by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_htu_down;
  import htu_pkg::*;

  typedef logic [14:0] exp_t;  // {hun, ten, uni, busy, done, zero}

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_load = 1'b0, in_start = 1'b0, in_hold = 1'b0, in_abort = 1'b0;
  logic [3:0] in_hun = '0, in_ten = '0, in_uni = '0;

  htu_if bus0();
  htu_if bus1();

  assign bus0.load = in_load;  assign bus1.load = in_load;
  assign bus0.load_hun = in_hun; assign bus1.load_hun = in_hun;
  assign bus0.load_ten = in_ten; assign bus1.load_ten = in_ten;
  assign bus0.load_uni = in_uni; assign bus1.load_uni = in_uni;
  assign bus0.start = in_start; assign bus1.start = in_start;
  assign bus0.hold = in_hold;  assign bus1.hold = in_hold;
  assign bus0.abort = in_abort; assign bus1.abort = in_abort;

  htu_down #(.UL(9), .DIV(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  htu_down #(.UL(9), .DIV(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: the count as a plain integer 0..999, a mode
  // (0 idle, 1 counting, 2 paused, 3 finished) and the number of unpaused
  // counting cycles since the last decrement.
  int c_div [2] = '{1, 4};
  int m_val [2];
  int m_mode[2];
  int m_phase[2];
  exp_t q0[$];
  exp_t q1[$];

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic exp_t expect_of(input int i);
    int v = m_val[i];
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10),
            (m_mode[i] == 1 || m_mode[i] == 2), (m_mode[i] == 3), (v == 0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_mode[i] = 0; m_phase[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int lv = clamp9(in_hun) * 100 + clamp9(in_ten) * 10 + clamp9(in_uni);
    if (in_abort) begin
      m_mode[i] = 0; m_phase[i] = 0;
    end else begin
      case (m_mode[i])
        0: begin
          m_phase[i] = 0;
          if (in_load) m_val[i] = lv;
          if (in_start) m_mode[i] = (m_val[i] != 0) ? 1 : 3;
        end
        1: begin
          if (in_hold) begin
            m_mode[i] = 2;
          end else begin
            m_phase[i] = m_phase[i] + 1;
            if (m_phase[i] == c_div[i]) begin
              m_phase[i] = 0;
              if (m_val[i] > 0) m_val[i] = m_val[i] - 1;
              if (m_val[i] == 0) m_mode[i] = 3;
            end
          end
        end
        2: begin
          if (in_load) m_val[i] = lv;
          if (!in_hold) m_mode[i] = (m_val[i] == 0) ? 3 : 1;
        end
        default: begin
          m_mode[i] = 0; m_phase[i] = 0;
        end
      endcase
    end
  endtask

  task automatic compare(input string name, input int i, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got h%0h t%0h u%0h busy%0b done%0b zero%0b want h%0h t%0h u%0h busy%0b done%0b zero%0b",
               name, i, $time, act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
               exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic exp_t actual(input int i);
    if (i == 0) return {bus0.hun, bus0.ten, bus0.uni, bus0.busy, bus0.done, bus0.zero};
    return {bus1.hun, bus1.ten, bus1.uni, bus1.busy, bus1.done, bus1.zero};
  endfunction

  // Monitor: outputs are presented once per cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) compare("cycle", 0, actual(0), q0.pop_front());
    if (q1.size() > 0) compare("cycle", 1, actual(1), q1.pop_front());
  end

  task automatic cycle(input logic l, input logic [3:0] h, input logic [3:0] t,
                       input logic [3:0] u, input logic s, input logic hd, input logic ab);
    @(negedge clk);
    in_load = l; in_hun = h; in_ten = t; in_uni = u;
    in_start = s; in_hold = hd; in_abort = ab;
    @(posedge clk);
    model_step(0);
    model_step(1);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  task automatic idle(input int n, input logic hd);
    repeat (n) cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, hd, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    compare("async_reset", 0, actual(0), 15'd1);
    compare("async_reset", 1, actual(1), 15'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    compare("reset_state", 0, actual(0), 15'd1);
    compare("reset_state", 1, actual(1), 15'd1);
    @(negedge clk);
    rst = 1'b1;

    // 003 countdown
    cycle(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    idle(18, 1'b0);
    // 100 -> 099 double borrow, run to 000
    cycle(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(410, 1'b0);
    // hold mid-period
    cycle(1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    idle(14, 1'b0);
    // start at 000
    cycle(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    // clamp, then load ignored while running
    cycle(1'b1, 4'hF, 4'hA, 4'h9, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 4'd4, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0);
    idle(24, 1'b0);
    // async reset mid-count
    cycle(1'b1, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    async_reset();
    idle(2, 1'b0);
    // abort mid-count keeps digits
    cycle(1'b1, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(1'b1, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    // load 000 while held finishes on release
    cycle(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // randomized traffic
    repeat (1500) begin
      logic [3:0] rh, rt, ru;
      rh = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      rt = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ru = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) == 0, rh, rt, ru,
            $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 39) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
